// File: rtl/target_hit_controller.sv
// rtl/target_hit_controller.sv - target hit detection, re-request on body collision, grow/score
//
// Purpose: requester side of the target-address handshake. Detects the snake
// head landing on the current target, pulses Reached_Target to the target
// generator, and scans the body for collisions with the new target.
// It re-requests on a collision, up to MAX_RETRY times. When a target is
// accepted it pulses Grow and adds SCORE_STEP to Score, saturating at 16'hFFFF.
//
// Ports:
//   CLK              in   system clock, all logic on posedge
//   RESET            in   synchronous active-high reset
//   Move_Tick        in   one-cycle pulse, Head_Address valid this cycle
//   Head_Address     in   snake head {x[7:0], y[6:0]}
//   Snake_Length     in   body length, 1..2**IDX_W
//   Target_Address   in   generator target {x[7:0], y[6:0]}
//   Body_Rd_Index    out  body RAM read index, 0 is the head
//   Body_Rd_Address  in   body segment for the index driven last cycle
//   Reached_Target   out  one-cycle request for a new target
//   Grow             out  one-cycle pulse when a target is accepted
//   Score            out  saturating binary score
//   Target_Valid     out  target is placed and may be drawn
//   Busy             out  high in every state except IDLE
//   Overrun          out  sticky, Move_Tick seen while Busy

module target_hit_controller #(
   parameter int IDX_W      = 6,
   parameter int MAX_RETRY  = 3,
   parameter int SCORE_STEP = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Move_Tick,
   input  logic [14:0]      Head_Address,
   input  logic [IDX_W:0]   Snake_Length,
   input  logic [14:0]      Target_Address,
   output logic [IDX_W-1:0] Body_Rd_Index,
   input  logic [14:0]      Body_Rd_Address,
   output logic             Reached_Target,
   output logic             Grow,
   output logic [15:0]      Score,
   output logic             Target_Valid,
   output logic             Busy,
   output logic             Overrun
);

   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SETTLE,
      SCAN,
      DONE
   } state_t;

   state_t             state;
   logic [IDX_W:0]     len_q;
   logic [IDX_W:0]     cmp_idx;   // index whose data is on Body_Rd_Address this cycle
   logic [RETRY_W-1:0] retry_q;

   logic [IDX_W:0]     last_idx;
   logic [16:0]        score_sum;
   logic [15:0]        score_next;
   logic               body_hit;

   always_comb begin
      last_idx   = len_q - 1'b1;
      score_sum  = {1'b0, Score} + 17'(SCORE_STEP);
      score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      body_hit   = (Body_Rd_Address == Target_Address);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state          <= IDLE;
         len_q          <= '0;
         cmp_idx        <= '0;
         retry_q        <= '0;
         Body_Rd_Index  <= '0;
         Reached_Target <= 1'b0;
         Grow           <= 1'b0;
         Score          <= 16'h0000;
         Target_Valid   <= 1'b1;
         Busy           <= 1'b0;
         Overrun        <= 1'b0;
      end else begin
         Reached_Target <= 1'b0;
         Grow           <= 1'b0;

         // A tick outside IDLE (including the DONE cycle) is dropped but recorded.
         if (Move_Tick && (state != IDLE))
            Overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (Move_Tick && (Head_Address == Target_Address)) begin
                  len_q          <= Snake_Length;
                  retry_q        <= '0;
                  Body_Rd_Index  <= '0;
                  Reached_Target <= 1'b1;
                  Target_Valid   <= 1'b0;
                  Busy           <= 1'b1;
                  state          <= REQ;
               end
            end

            REQ: begin
               Body_Rd_Index <= '0;
               state         <= SETTLE;
            end

            // Index 0 is on the RAM address this cycle; its data arrives in the
            // first SCAN cycle, so the next index is already put out here.
            SETTLE: begin
               cmp_idx <= '0;
               if (last_idx != '0)
                  Body_Rd_Index <= IDX_W'(1);
               state <= SCAN;
            end

            SCAN: begin
               if (body_hit) begin
                  if (int'(retry_q) < MAX_RETRY) begin
                     retry_q        <= retry_q + RETRY_W'(1);
                     Reached_Target <= 1'b1;
                     state          <= REQ;
                  end else begin
                     // Retry budget spent: accept the colliding target.
                     Grow         <= 1'b1;
                     Target_Valid <= 1'b1;
                     Score        <= score_next;
                     state        <= DONE;
                  end
               end else if (cmp_idx == last_idx) begin
                  Grow         <= 1'b1;
                  Target_Valid <= 1'b1;
                  Score        <= score_next;
                  state        <= DONE;
               end else begin
                  cmp_idx <= cmp_idx + 1'b1;
                  // Read index stops at len_q-1; never drive past the body.
                  if ({1'b0, Body_Rd_Index} < last_idx)
                     Body_Rd_Index <= Body_Rd_Index + 1'b1;
               end
            end

            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_target_hit_controller.sv
// tb/tb_target_hit_controller.sv - scoreboard bench for target_hit_controller

module tb_target_hit_controller;

   localparam int IDX_W = 6;
   // Large step so score saturation is reached in a handful of hits.
   localparam int STEP  = 32'h7FFF;

   logic             CLK = 1'b0;
   logic             RESET = 1'b1;
   logic             Move_Tick = 1'b0;
   logic [14:0]      Head_Address = '0;
   logic [IDX_W:0]   Snake_Length = 7'd1;
   logic [14:0]      Target_Address;
   logic [IDX_W-1:0] Body_Rd_Index;
   logic [14:0]      Body_Rd_Address;
   logic             Reached_Target;
   logic             Grow;
   logic [15:0]      Score;
   logic             Target_Valid;
   logic             Busy;
   logic             Overrun;

   target_hit_controller #(
      .IDX_W      (IDX_W),
      .MAX_RETRY  (3),
      .SCORE_STEP (STEP)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .Move_Tick       (Move_Tick),
      .Head_Address    (Head_Address),
      .Snake_Length    (Snake_Length),
      .Target_Address  (Target_Address),
      .Body_Rd_Index   (Body_Rd_Index),
      .Body_Rd_Address (Body_Rd_Address),
      .Reached_Target  (Reached_Target),
      .Grow            (Grow),
      .Score           (Score),
      .Target_Valid    (Target_Valid),
      .Busy            (Busy),
      .Overrun         (Overrun)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int kind;   // 0 = Reached_Target pulse, 1 = Grow pulse
      int rel;    // cycles after the tick cycle
      int score;  // expected Score during Grow
   } ev_t;

   ev_t         exp_q[$];
   logic [14:0] gen_q[$];
   logic [14:0] body[64];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          tick_cyc = 0;
   logic        rt_prev = 1'b0;

   function automatic logic [14:0] xy(input int x, input int y);
      return {x[7:0], y[6:0]};
   endfunction

   localparam logic [14:0] T0 = {8'd55, 7'd13};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_req(input int rel);
      ev_t e;
      e.kind = 0; e.rel = rel; e.score = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_grow(input int rel, input int score);
      ev_t e;
      e.kind = 1; e.rel = rel; e.score = score;
      exp_q.push_back(e);
   endtask

   // Drive a one-cycle tick; returns at the falling edge of the cycle after it.
   task automatic tick(input logic [14:0] head, input int len);
      Head_Address = head;
      Snake_Length = 7'(len);
      Move_Tick    = 1'b1;
      tick_cyc     = cyc;
      @(negedge CLK);
      Move_Tick    = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge CLK);
         k++;
      end
      chk("drain_pending", exp_q.size(), 0);
      repeat (2) @(negedge CLK);
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Target generator: reset target T0, next target from gen_q on each request.
   always @(posedge CLK) begin
      if (RESET)
         Target_Address <= T0;
      else if (Reached_Target && gen_q.size() > 0)
         Target_Address <= gen_q.pop_front();
   end

   // Body RAM: one-cycle read latency.
   always @(posedge CLK) Body_Rd_Address <= body[Body_Rd_Index];

   // Monitor: pops the scoreboard whenever the DUT pulses a request or grow.
   always @(negedge CLK) begin
      ev_t e;
      if (Reached_Target === 1'b1 || Grow === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: rt=%0b grow=%0b rel=%0d, required no event",
                     Reached_Target, Grow, cyc - tick_cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", Grow ? 1 : 0, e.kind);
            chk("event_rel", cyc - tick_cyc, e.rel);
            if (e.kind == 1) begin
               chk("grow_score", Score, e.score);
               chk("grow_target_valid", Target_Valid, 1);
            end else begin
               chk("req_target_valid", Target_Valid, 0);
            end
         end
      end
      if (Reached_Target === 1'b1)
         chk("req_back_to_back", rt_prev, 0);
      rt_prev = Reached_Target;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) body[i] = xy(200, i);

      // Reset state
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_reached", Reached_Target, 0);
      chk("rst_grow", Grow, 0);
      chk("rst_score", Score, 0);
      chk("rst_overrun", Overrun, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_index", Body_Rd_Index, 0);
      chk("rst_target_valid", Target_Valid, 1);
      RESET = 1'b0;
      @(negedge CLK);

      // Clean hit, length 4; length change mid-transaction must be ignored
      gen_q.push_back(xy(10, 5));
      push_req(1);
      push_grow(7, 16'h7FFF);
      tick(T0, 4);
      Snake_Length = 7'd1;
      chk("hit_busy", Busy, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("rd_index", Body_Rd_Index, (k < 4) ? k : 3);
      end
      drain();
      chk("hit_score", Score, 16'h7FFF);
      chk("hit_target_valid", Target_Valid, 1);
      chk("hit_idle", Busy, 0);

      // Miss: head one column off the target
      tick(xy(54, 13), 4);
      chk("miss_busy_1", Busy, 0);
      @(negedge CLK);
      chk("miss_busy_2", Busy, 0);
      repeat (8) @(negedge CLK);
      chk("miss_score", Score, 16'h7FFF);
      chk("miss_overrun", Overrun, 0);

      // Tick during SCAN whose head matches the new target: dropped, Overrun set
      gen_q.push_back(xy(20, 20));
      push_req(1);
      push_grow(11, 16'hFFFE);
      tick(xy(10, 5), 8);
      repeat (3) @(negedge CLK);
      Head_Address = xy(20, 20);
      Move_Tick = 1'b1;
      @(negedge CLK);
      Move_Tick = 1'b0;
      chk("overrun_set", Overrun, 1);
      drain();
      chk("overrun_sticky", Overrun, 1);
      chk("overrun_score", Score, 16'hFFFE);
      RESET = 1'b1;
      @(negedge CLK);
      chk("reset_overrun", Overrun, 0);
      chk("reset_score", Score, 0);
      chk("reset_target_valid", Target_Valid, 1);
      RESET = 1'b0;
      @(negedge CLK);

      // Segment 2 collides with the first new target once
      body[2] = xy(30, 30);
      gen_q.push_back(xy(30, 30));
      gen_q.push_back(xy(40, 40));
      push_req(1);
      push_req(6);
      push_grow(12, 16'h7FFF);
      tick(T0, 4);
      drain();
      body[2] = xy(200, 2);
      chk("retry1_score", Score, 16'h7FFF);

      // Every new target collides with segment 0: 1 + MAX_RETRY requests
      body[0] = xy(60, 60);
      for (int k = 0; k < 4; k++) gen_q.push_back(xy(60, 60));
      push_req(1);
      push_req(4);
      push_req(7);
      push_req(10);
      push_grow(13, 16'hFFFE);
      tick(xy(40, 40), 4);
      drain();
      body[0] = xy(200, 0);
      chk("maxretry_target_valid", Target_Valid, 1);
      chk("maxretry_score", Score, 16'hFFFE);

      // Saturation from FFFE
      gen_q.push_back(xy(70, 70));
      push_req(1);
      push_grow(4, 16'hFFFF);
      tick(xy(60, 60), 1);
      drain();
      gen_q.push_back(xy(80, 80));
      push_req(1);
      push_grow(5, 16'hFFFF);
      tick(xy(70, 70), 2);
      drain();
      chk("sat_score", Score, 16'hFFFF);

      // RESET during SCAN abandons the transaction
      gen_q.push_back(xy(90, 90));
      push_req(1);
      tick(xy(80, 80), 8);
      repeat (3) @(negedge CLK);
      chk("scan_busy", Busy, 1);
      RESET = 1'b1;
      @(negedge CLK);
      chk("scanrst_busy", Busy, 0);
      chk("scanrst_score", Score, 0);
      chk("scanrst_target_valid", Target_Valid, 1);
      chk("scanrst_grow", Grow, 0);
      chk("scanrst_index", Body_Rd_Index, 0);
      RESET = 1'b0;
      repeat (15) @(negedge CLK);
      chk("scanrst_no_events", exp_q.size(), 0);
      chk("scanrst_score_after", Score, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/target_hit_controller.md
Name: target_hit_controller

Overview:
- Requester side of the target-address handshake: detects the snake head landing on the current target and pulses Reached_Target to the target generator.
- After the generator responds, scans the snake body for collisions with the new target. Re-requests on collision, up to a retry limit.
- On each accepted target, emits a one-cycle grow pulse and updates the score.
- Sits between the snake movement logic / body RAM and the target generator, on the same CLK.

Parameters:
- IDX_W, 6: body index width; maximum snake length 2**IDX_W = 64.
- MAX_RETRY, 3: maximum re-requests after body collisions before the target is accepted anyway.
- SCORE_STEP, 1: score increment per eaten target.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- Move_Tick  in  1  one-cycle pulse; Head_Address is updated and stable this cycle.
- Head_Address  in  15  snake head, {x[7:0], y[6:0]}.
- Snake_Length  in  IDX_W+1  current body length, 1..2**IDX_W.
- Target_Address  in  15  generator output, {x[7:0], y[6:0]}; updates one edge after Reached_Target is sampled.
- Body_Rd_Index  out  IDX_W  body RAM read index; 0 is the head.
- Body_Rd_Address  in  15  body segment at Body_Rd_Index, valid one cycle after the index is driven.
- Reached_Target  out  1  one-cycle request for a new target.
- Grow  out  1  one-cycle pulse when a new target is accepted.
- Score  out  16  binary score.
- Target_Valid  out  1  target is placed and may be drawn.
- Busy  out  1  high in every state except IDLE.
- Overrun  out  1  sticky; set when Move_Tick arrives while Busy.

Behaviour:
- Reset values:
  - State IDLE.
  - Reached_Target=0, Grow=0, Score=0, Overrun=0, Busy=0, Body_Rd_Index=0.
  - Target_Valid=1: the generator's reset target is valid.
  - Retry counter 0.
- RESET asserted in any state returns everything to the reset values on the next edge. A request already issued is abandoned.
- IDLE:
  - On Move_Tick with Head_Address==Target_Address (all 15 bits): latch Snake_Length into len_q, clear the retry counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ (1 cycle):
  - Reached_Target=1, Target_Valid=0.
  - Next state SETTLE.
- SETTLE (1 cycle):
  - Target_Address now carries the new value.
  - Drive Body_Rd_Index=0.
  - Next state SCAN.
- SCAN:
  - Each cycle, compare Body_Rd_Address (for the index driven the previous cycle) with Target_Address.
  - Then advance Body_Rd_Index until len_q-1. Indices past len_q-1 are never driven.
  - Match, retry < MAX_RETRY: increment retry, go to REQ.
  - Match, retry == MAX_RETRY: go to DONE (target accepted despite collision).
  - Compare of index len_q-1 with no match: go to DONE.
  - A clean scan takes len_q cycles after SETTLE.
- DONE (1 cycle):
  - Grow=1, Target_Valid=1.
  - Score <= Score+SCORE_STEP, saturating at 16'hFFFF.
  - Next state IDLE.
- Move_Tick while Busy:
  - Ignored for hit detection.
  - Sets Overrun; Overrun clears only on RESET.
- Move_Tick in the same cycle as the DONE→IDLE transition is treated as Busy and is dropped.
- len_q is frozen for the whole transaction; Snake_Length changes mid-scan have no effect.
- Reached_Target is never high for two consecutive cycles. Minimum gap between requests is 2 cycles (REQ, SETTLE, ≥1 SCAN).
- Clean-hit latency, Move_Tick to Grow: 3+len_q cycles.

Test Plan:
- Reset, then Move_Tick with Head={8'd55,7'd13}, Target={8'd55,7'd13}, Length=4:
  - Reached_Target high exactly 1 cycle, the cycle after the tick.
  - Body_Rd_Index 0,1,2,3.
  - Grow pulses 7 cycles after the tick; Score=1; Target_Valid=1.
- Head={8'd54,7'd13} ≠ Target → no Reached_Target, Busy stays 0, Score unchanged.
- Body model returns segment 2 == new Target once:
  - Second Reached_Target pulse after the compare of index 2.
  - Second target clean → single Grow, Score+1.
- Body model always collides (segment 0 == Target):
  - Exactly 4 Reached_Target pulses (1 + MAX_RETRY).
  - Then Grow, Target_Valid=1.
- Move_Tick during SCAN → Overrun=1 and stays 1; hit not double-counted. RESET clears Overrun.
- Preload Score=16'hFFFE via repeated hits → two more hits yield FFFF, FFFF.
- RESET during SCAN → next cycle IDLE, Score=0, Target_Valid=1, no Grow.
